sys_run_ctrl: RTL and testbench

Run/step/halt sequencer between the board controls and the single-cycle processor datapath in `system`. It turns the `SYS_load`/`SYS_pc_val` controls into a one-cycle PC write and drives the per-instruction commit enable for the datapath in free-run or single-step mode. It halts on a datapath exception or at the end of instruction memory, and keeps a saturating retired-instruction count for the LED/debug mux.

---
 rtl/sys_run_ctrl_if.sv | 13 +
 rtl/sys_run_ctrl.sv | 125 ++++++++++++
 tb/tb_sys_run_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_run_ctrl_if.sv
// rtl/sys_run_ctrl_if.sv - datapath-side link between the run controller and the single-cycle CPU
interface sys_run_ctrl_if #(
  parameter int PC_W = 8
);
  logic            pc_we;
  logic [PC_W-1:0] pc_wdata;
  logic            cpu_en;
  logic [PC_W-1:0] cpu_pc;
  logic            cpu_exc;

  modport master (output pc_we, output pc_wdata, output cpu_en, input cpu_pc, input cpu_exc);
  modport slave  (input pc_we, input pc_wdata, input cpu_en, output cpu_pc, output cpu_exc);
endinterface

// File: rtl/sys_run_ctrl.sv
// rtl/sys_run_ctrl.sv - run/step/halt sequencer with PC load, exception halt and retired count
// Optional breakpoint exit in RUN is enabled by defining SYS_BREAKPOINT_EN.
module sys_run_ctrl #(
  parameter int              PC_W     = 8,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] PC_LIMIT = 8'hFC
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              SYS_load,
  input  logic [PC_W-1:0]   SYS_pc_val,
  input  logic              run_req,
  input  logic              step_req,
  input  logic [PC_W-1:0]   bp_addr,
  sys_run_ctrl_if.master    dp,
  output logic              halted,
  output logic              exc_flag,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic            step_q;
  logic            step_edge;
  logic            at_limit;
  logic            commit_ok;
  logic            en;
  logic            set_exc;
  logic [PC_W-1:0] wdata_q;

  assign step_edge = step_req & ~step_q;
  assign at_limit  = (dp.cpu_pc == PC_LIMIT);
  assign commit_ok = ~SYS_load & ~dp.cpu_exc & ~at_limit;

`ifdef SYS_BREAKPOINT_EN
  logic bp_hit;
  assign bp_hit = (dp.cpu_pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^bp_addr;
`endif

  always_comb begin
    nxt     = cur;
    en      = 1'b0;
    set_exc = 1'b0;
    case (cur)
      IDLE: begin
        if (SYS_load)       nxt = LOAD;
        else if (run_req)   nxt = RUN;
        else if (step_edge) nxt = STEP;
      end
      LOAD: nxt = IDLE;
      RUN: begin
`ifdef SYS_BREAKPOINT_EN
        en = commit_ok & ~bp_hit;
`else
        en = commit_ok;
`endif
        if (SYS_load) nxt = LOAD;
        else if (dp.cpu_exc) begin
          nxt     = HALT;
          set_exc = 1'b1;
        end
`ifdef SYS_BREAKPOINT_EN
        else if (bp_hit)   nxt = IDLE;
`endif
        else if (at_limit) nxt = HALT;
        else if (!run_req) nxt = IDLE;
      end
      // Single commit slot; the breakpoint is deliberately not checked so a step moves past it.
      STEP: begin
        en = commit_ok;
        if (SYS_load) nxt = LOAD;
        else if (dp.cpu_exc) begin
          nxt     = HALT;
          set_exc = 1'b1;
        end
        else if (at_limit) nxt = HALT;
        else               nxt = IDLE;
      end
      HALT: begin
        if (SYS_load) nxt = LOAD;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      cur       <= IDLE;
      step_q    <= 1'b0;
      wdata_q   <= '0;
      exc_flag  <= 1'b0;
      instr_cnt <= '0;
    end else begin
      cur    <= nxt;
      step_q <= step_req;
      if (nxt == LOAD) begin
        wdata_q   <= SYS_pc_val;
        exc_flag  <= 1'b0;
        instr_cnt <= '0;
      end else begin
        if (set_exc) exc_flag <= 1'b1;
        if (en && (instr_cnt != {CNT_W{1'b1}})) instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end

  assign dp.pc_we    = (cur == LOAD);
  assign dp.pc_wdata = wdata_q;
  assign dp.cpu_en   = en;
  assign halted      = (cur == HALT);
  assign state       = cur;

endmodule

// File: tb/tb_sys_run_ctrl.sv
// tb/tb_sys_run_ctrl.sv - directed self-checking bench for sys_run_ctrl
module tb_sys_run_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        load;
  logic [7:0]  pc_val;
  logic        run;
  logic        step;
  logic [7:0]  bp;
  logic        halted;
  logic        exc_flag;
  logic [2:0]  state;
  logic [15:0] instr_cnt;

  logic        exc_arm;
  logic [7:0]  exc_pc;
  int          en_count;

  logic        run2;
  logic        halted2;
  logic        exc_flag2;
  logic [2:0]  state2;
  logic [3:0]  instr_cnt2;

  int vectors = 0;
  int errors  = 0;

  sys_run_ctrl_if #(.PC_W(8)) d_if ();
  sys_run_ctrl_if #(.PC_W(8)) s_if ();

  sys_run_ctrl dut (
    .SYS_clk(clk), .SYS_reset(rstn), .SYS_load(load), .SYS_pc_val(pc_val),
    .run_req(run), .step_req(step), .bp_addr(bp), .dp(d_if.master),
    .halted(halted), .exc_flag(exc_flag), .state(state), .instr_cnt(instr_cnt)
  );

  sys_run_ctrl #(.CNT_W(4)) dut_sat (
    .SYS_clk(clk), .SYS_reset(rstn), .SYS_load(1'b0), .SYS_pc_val(8'h00),
    .run_req(run2), .step_req(1'b0), .bp_addr(8'h80), .dp(s_if.master),
    .halted(halted2), .exc_flag(exc_flag2), .state(state2), .instr_cnt(instr_cnt2)
  );

  always #5 clk = ~clk;

  // Datapath model: PC load wins, otherwise advance by 4 on each committed instruction.
  always @(posedge clk) begin
    if (!rstn)             d_if.cpu_pc <= 8'h00;
    else if (d_if.pc_we)   d_if.cpu_pc <= d_if.pc_wdata;
    else if (d_if.cpu_en)  d_if.cpu_pc <= d_if.cpu_pc + 8'h04;
  end
  assign d_if.cpu_exc = exc_arm && (d_if.cpu_pc == exc_pc);
  assign s_if.cpu_pc  = 8'h00;
  assign s_if.cpu_exc = 1'b0;

  always @(negedge clk) if (d_if.cpu_en === 1'b1) en_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; pc_val = v;
    tick(1);
    load = 1'b0;
    tick(1);
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; pc_val = 8'h00; run = 1'b0; step = 1'b0;
    bp = 8'h0C; exc_arm = 1'b0; exc_pc = 8'h14; run2 = 1'b0; en_count = 0;
    tick(1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_we", 32'(d_if.pc_we), 32'd0);
    check("rst_pc_wdata", 32'(d_if.pc_wdata), 32'h00);
    check("rst_cpu_en", 32'(d_if.cpu_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_exc_flag", 32'(exc_flag), 32'd0);
    check("rst_instr_cnt", 32'(instr_cnt), 32'd0);
    rstn = 1'b1;

    // Load 0x10: strobe one cycle later, back to IDLE the cycle after
    load = 1'b1; pc_val = 8'h10;
    tick(1);
    check("load_state", 32'(state), 32'd1);
    check("load_pc_we", 32'(d_if.pc_we), 32'd1);
    check("load_pc_wdata", 32'(d_if.pc_wdata), 32'h10);
    check("load_cnt", 32'(instr_cnt), 32'd0);
    load = 1'b0;
    tick(1);
    check("load_back_idle", 32'(state), 32'd0);
    check("load_pc_we_drop", 32'(d_if.pc_we), 32'd0);
    check("load_cpu_pc", 32'(d_if.cpu_pc), 32'h10);

    // Free run for 20 instructions from PC 0
    do_load(8'h00);
    en_count = 0;
    run = 1'b1;
    tick(1);
    check("run_first_en", 32'(d_if.cpu_en), 32'd1);
    tick(19);
    run = 1'b0;
    tick(1);
    check("run_idle", 32'(state), 32'd0);
    check("run_en_count", 32'(en_count), 32'd20);
    check("run_cnt", 32'(instr_cnt), 32'd20);
    check("run_cpu_pc", 32'(d_if.cpu_pc), 32'h50);

    // Three separated step pulses, then one held step
    do_load(8'h00);
    en_count = 0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(4);
    end
    check("step3_en_count", 32'(en_count), 32'd3);
    check("step3_cnt", 32'(instr_cnt), 32'd3);
    check("step3_cpu_pc", 32'(d_if.cpu_pc), 32'h0C);
    en_count = 0;
    step = 1'b1;
    tick(10);
    step = 1'b0;
    tick(1);
    check("step_held_en_count", 32'(en_count), 32'd1);
    check("step_held_cnt", 32'(instr_cnt), 32'd4);

    // Exception on the 6th instruction (PC 0x14)
    do_load(8'h00);
    exc_arm = 1'b1;
    run = 1'b1;
    tick(6);
    check("exc_cpu_pc", 32'(d_if.cpu_pc), 32'h14);
    check("exc_cpu_en", 32'(d_if.cpu_en), 32'd0);
    tick(1);
    check("exc_state", 32'(state), 32'd4);
    check("exc_halted", 32'(halted), 32'd1);
    check("exc_flag_set", 32'(exc_flag), 32'd1);
    check("exc_cnt", 32'(instr_cnt), 32'd5);
    run = 1'b0;
    tick(2);
    run = 1'b1; step = 1'b1;
    tick(2);
    run = 1'b0; step = 1'b0;
    tick(1);
    check("halt_sticky", 32'(state), 32'd4);
    check("halt_cnt_hold", 32'(instr_cnt), 32'd5);
    exc_arm = 1'b0;
    load = 1'b1; pc_val = 8'h00;
    tick(1);
    load = 1'b0;
    check("halt_to_load", 32'(state), 32'd1);
    check("load_clears_exc", 32'(exc_flag), 32'd0);
    tick(1);
    check("halt_cleared", 32'(halted), 32'd0);

    // End-of-program halt at PC 0xFC
    do_load(8'hF0);
    run = 1'b1;
    tick(4);
    check("limit_cpu_pc", 32'(d_if.cpu_pc), 32'hFC);
    check("limit_cpu_en", 32'(d_if.cpu_en), 32'd0);
    tick(1);
    run = 1'b0;
    check("limit_state", 32'(state), 32'd4);
    check("limit_exc_flag", 32'(exc_flag), 32'd0);
    check("limit_cnt", 32'(instr_cnt), 32'd3);

    // Breakpoint at 0x0C: resumable stop when enabled, ignored otherwise
    do_load(8'h00);
    run = 1'b1;
    tick(4);
`ifdef SYS_BREAKPOINT_EN
    check("bp_cpu_en", 32'(d_if.cpu_en), 32'd0);
    run = 1'b0;
    tick(1);
    check("bp_state", 32'(state), 32'd0);
    check("bp_halted", 32'(halted), 32'd0);
    check("bp_cpu_pc", 32'(d_if.cpu_pc), 32'h0C);
    check("bp_cnt", 32'(instr_cnt), 32'd3);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);
    check("bp_step_pc", 32'(d_if.cpu_pc), 32'h10);
    check("bp_step_cnt", 32'(instr_cnt), 32'd4);
`else
    check("nobp_cpu_en", 32'(d_if.cpu_en), 32'd1);
    run = 1'b0;
    tick(1);
    check("nobp_state", 32'(state), 32'd0);
    check("nobp_cpu_pc", 32'(d_if.cpu_pc), 32'h10);
    check("nobp_cnt", 32'(instr_cnt), 32'd4);
`endif

    // Counter saturation on the 4-bit instance
    check("sat_pre", 32'(instr_cnt2), 32'd0);
    run2 = 1'b1;
    tick(15);
    check("sat_e", 32'(instr_cnt2), 32'hE);
    tick(5);
    check("sat_f", 32'(instr_cnt2), 32'hF);
    check("sat_state", 32'(state2), 32'd2);
    run2 = 1'b0;

    // Reset mid-RUN
    run = 1'b1;
    tick(3);
    rstn = 1'b0;
    tick(1);
    check("rst_run_state", 32'(state), 32'd0);
    check("rst_run_en", 32'(d_if.cpu_en), 32'd0);
    check("rst_run_cnt", 32'(instr_cnt), 32'd0);
    run = 1'b0;
    rstn = 1'b1;
    tick(1);

    // Reset mid-LOAD leaves no partial strobe
    load = 1'b1; pc_val = 8'h55;
    tick(1);
    check("mid_load_we", 32'(d_if.pc_we), 32'd1);
    rstn = 1'b0; load = 1'b0;
    tick(1);
    check("rst_load_we", 32'(d_if.pc_we), 32'd0);
    check("rst_load_wdata", 32'(d_if.pc_wdata), 32'h00);
    check("rst_load_state", 32'(state), 32'd0);
    rstn = 1'b1;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
